itlb_refill: RTL and testbench

Miss handler and write-side controller for the instruction TLB. When fetch reports an ITLB miss, the block reads the page-table entry (PTE) from memory and installs the translation into a TLB line chosen by round-robin replacement. If the PTE is invalid, it signals a page fault instead. It also performs a whole-TLB flush on request. It sits between the fetch stage, the ITLB write ports and the instruction-side memory read port.

---
 rtl/itlb_pkg.sv | 19 +
 rtl/itlb_refill.sv | 118 +++++++++++
 tb/tb_itlb_refill.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/itlb_pkg.sv
// Shared constants for the instruction-TLB refill controller:
// PTE field positions, FSM state encoding and default parameter values.
package itlb_pkg;

    // PTE layout: bit15 = valid, bits9:0 = PPN, bits14:10 reserved
    localparam int unsigned PTE_VALID_BIT = 15;
    localparam int unsigned PTE_PPN_MSB   = 9;

    // Refill FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // Defaults: page-table base, and a victim start that spares boot entries 0 and 1
    localparam logic [15:0] DEFAULT_PTBR         = 16'h0800;
    localparam int unsigned DEFAULT_RESET_VICTIM = 2;

endpackage

// File: rtl/itlb_refill.sv
// ITLB miss handler: walks a single-level page table on a fetch miss,
// installs the translation into a round-robin victim line or raises a
// page fault, and performs whole-TLB flushes from IDLE.
module itlb_refill
    import itlb_pkg::*;
#(
    parameter int unsigned            addr_width        = 16,
    parameter int unsigned            tag_bits_per_addr = 10,
    parameter int unsigned            num_tlb_lines     = 4,
    parameter logic [addr_width-1:0]  ptbr              = addr_width'(DEFAULT_PTBR),
    parameter int unsigned            reset_victim      = DEFAULT_RESET_VICTIM
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         miss_req,
    input  logic [tag_bits_per_addr-1:0] miss_vpn,
    input  logic                         flush,
    output logic                         mem_req,
    output logic [addr_width-1:0]        mem_addr,
    input  logic                         mem_ready,
    input  logic [15:0]                  mem_rdata,
    output logic [num_tlb_lines-1:0]     tlb_we,
    output logic [tag_bits_per_addr-1:0] tlb_wr_vpn,
    output logic [tag_bits_per_addr-1:0] tlb_wr_ppn,
    output logic                         tlb_wr_valid,
    output logic                         done,
    output logic                         page_fault,
    output logic [tag_bits_per_addr-1:0] fault_vpn
);

    localparam int unsigned VW = (num_tlb_lines > 1) ? $clog2(num_tlb_lines) : 1;

    logic [1:0]                   state;
    logic [tag_bits_per_addr-1:0] vpn_r;
    logic [tag_bits_per_addr-1:0] ppn_r;
    logic [VW-1:0]                victim;
    logic [tag_bits_per_addr-1:0] fault_vpn_r;

    // Reserved PTE bits are deliberately ignored
    logic unused_pte_bits;
    assign unused_pte_bits = ^mem_rdata[PTE_VALID_BIT-1:PTE_PPN_MSB+1];

    // FSM, PTE capture, victim pointer and fault VPN register
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            vpn_r       <= '0;
            ppn_r       <= '0;
            victim      <= VW'(reset_victim);
            fault_vpn_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!flush && miss_req) begin
                        vpn_r <= miss_vpn;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (mem_ready) begin
                        ppn_r <= tag_bits_per_addr'(mem_rdata[PTE_PPN_MSB:0]);
                        if (mem_rdata[PTE_VALID_BIT]) begin
                            state <= ST_FILL;
                        end else begin
                            // Captured here so fault_vpn is valid alongside page_fault
                            fault_vpn_r <= vpn_r;
                            state       <= ST_FAULT;
                        end
                    end
                end
                ST_FILL: begin
                    victim <= victim + VW'(1);
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state, plus the combinational flush path
    always_comb begin
        mem_req      = 1'b0;
        mem_addr     = '0;
        tlb_we       = '0;
        tlb_wr_vpn   = '0;
        tlb_wr_ppn   = '0;
        tlb_wr_valid = 1'b0;
        done         = 1'b0;
        page_fault   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush) begin
                    tlb_we = '1;
                end
            end
            ST_READ: begin
                mem_req  = 1'b1;
                mem_addr = ptbr + addr_width'({vpn_r, 1'b0});
            end
            ST_FILL: begin
                tlb_we[victim] = 1'b1;
                tlb_wr_vpn     = vpn_r;
                tlb_wr_ppn     = ppn_r;
                tlb_wr_valid   = 1'b1;
                done           = 1'b1;
            end
            default: begin
                done       = 1'b1;
                page_fault = 1'b1;
            end
        endcase
    end

    assign fault_vpn = fault_vpn_r;

endmodule

// File: tb/tb_itlb_refill.sv
// Directed self-checking bench for itlb_refill. A second instance with a
// high page-table base checks that the PTE address wraps modulo 2^16.
module tb_itlb_refill;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_req;
    logic [9:0]  miss_vpn;
    logic        flush;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    logic        mem_req,   w_mem_req;
    logic [15:0] mem_addr,  w_mem_addr;
    logic [3:0]  tlb_we,    w_tlb_we;
    logic [9:0]  tlb_wr_vpn, w_tlb_wr_vpn;
    logic [9:0]  tlb_wr_ppn, w_tlb_wr_ppn;
    logic        tlb_wr_valid, w_tlb_wr_valid;
    logic        done,      w_done;
    logic        page_fault, w_page_fault;
    logic [9:0]  fault_vpn, w_fault_vpn;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    itlb_refill u_dut (
        .clk(clk), .reset(reset), .miss_req(miss_req), .miss_vpn(miss_vpn),
        .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .tlb_we(tlb_we),
        .tlb_wr_vpn(tlb_wr_vpn), .tlb_wr_ppn(tlb_wr_ppn),
        .tlb_wr_valid(tlb_wr_valid), .done(done), .page_fault(page_fault),
        .fault_vpn(fault_vpn)
    );

    itlb_refill #(.ptbr(16'hF900)) u_wrap (
        .clk(clk), .reset(reset), .miss_req(miss_req), .miss_vpn(miss_vpn),
        .flush(flush), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .tlb_we(w_tlb_we),
        .tlb_wr_vpn(w_tlb_wr_vpn), .tlb_wr_ppn(w_tlb_wr_ppn),
        .tlb_wr_valid(w_tlb_wr_valid), .done(w_done), .page_fault(w_page_fault),
        .fault_vpn(w_fault_vpn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single refill with mem_ready in the first READ cycle
    task automatic refill(input logic [9:0] vpn, input logic [15:0] pte,
                          input logic [15:0] exp_addr, input logic [3:0] exp_we);
        miss_req = 1'b1;
        miss_vpn = vpn;
        tick();                                   // READ
        mem_ready = 1'b1;
        mem_rdata = pte;
        #1;
        chk("rf_mem_req", 32'(mem_req), 32'd1);
        chk("rf_mem_addr", 32'(mem_addr), 32'(exp_addr));
        tick();                                   // FILL
        mem_ready = 1'b0;
        miss_req  = 1'b0;
        #1;
        chk("rf_tlb_we", 32'(tlb_we), 32'(exp_we));
        chk("rf_wr_vpn", 32'(tlb_wr_vpn), 32'(vpn));
        chk("rf_wr_ppn", 32'(tlb_wr_ppn), 32'(pte[9:0]));
        chk("rf_done", 32'(done), 32'd1);
        tick();                                   // IDLE
    endtask

    initial begin
        reset     = 1'b1;
        miss_req  = 1'b0;
        miss_vpn  = '0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        tick();

        // Reset state
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_tlb_we", 32'(tlb_we), 32'd0);
        chk("rst_wr_vpn", 32'(tlb_wr_vpn), 32'd0);
        chk("rst_wr_ppn", 32'(tlb_wr_ppn), 32'd0);
        chk("rst_wr_valid", 32'(tlb_wr_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_page_fault", 32'(page_fault), 32'd0);
        chk("rst_fault_vpn", 32'(fault_vpn), 32'd0);
        reset = 1'b0;

        // Miss on VPN 0x00A with three wait cycles, PTE 0x8002
        miss_req = 1'b1;
        miss_vpn = 10'h00A;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("wait_mem_req", 32'(mem_req), 32'd1);
            chk("wait_mem_addr", 32'(mem_addr), 32'h0814);
            chk("wait_no_we", 32'(tlb_we), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h8002;
        #1;
        chk("ready_mem_req", 32'(mem_req), 32'd1);
        chk("ready_mem_addr", 32'(mem_addr), 32'h0814);
        tick();
        mem_ready = 1'b0;
        miss_req  = 1'b0;
        #1;
        chk("fill_mem_req", 32'(mem_req), 32'd0);
        chk("fill_tlb_we", 32'(tlb_we), 32'b0100);
        chk("fill_wr_vpn", 32'(tlb_wr_vpn), 32'h00A);
        chk("fill_wr_ppn", 32'(tlb_wr_ppn), 32'h002);
        chk("fill_wr_valid", 32'(tlb_wr_valid), 32'd1);
        chk("fill_done", 32'(done), 32'd1);
        chk("fill_no_fault", 32'(page_fault), 32'd0);
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_tlb_we", 32'(tlb_we), 32'd0);

        // Invalid PTE for VPN 0x155
        miss_req = 1'b1;
        miss_vpn = 10'h155;
        tick();
        mem_ready = 1'b1;
        mem_rdata = 16'h0005;
        #1;
        chk("flt_mem_addr", 32'(mem_addr), 32'h0AAA);
        tick();
        mem_ready = 1'b0;
        miss_req  = 1'b0;
        #1;
        chk("flt_page_fault", 32'(page_fault), 32'd1);
        chk("flt_done", 32'(done), 32'd1);
        chk("flt_fault_vpn", 32'(fault_vpn), 32'h155);
        chk("flt_tlb_we", 32'(tlb_we), 32'd0);
        tick();
        chk("flt_pulse_end", 32'(page_fault), 32'd0);
        chk("flt_vpn_held", 32'(fault_vpn), 32'h155);

        // Back-to-back refills: victim still 3 after the fault, then wraps
        refill(10'h011, 16'h8031, 16'h0822, 4'b1000);
        refill(10'h3FF, 16'h83FF, 16'h0FFE, 4'b0001);
        chk("wrap_addr_prev", 32'(w_mem_addr), 32'd0);
        refill(10'h020, 16'hFC07, 16'h0840, 4'b0010);
        refill(10'h100, 16'h8100, 16'h0A00, 4'b0100);

        // PTE address carry-out discarded: 0xF900 + 0x7FE -> 0x00FE
        miss_req = 1'b1;
        miss_vpn = 10'h3FF;
        tick();
        chk("wrap_mem_req", 32'(w_mem_req), 32'd1);
        chk("wrap_mem_addr", 32'(w_mem_addr), 32'h00FE);
        mem_ready = 1'b1;
        mem_rdata = 16'h8155;
        tick();
        mem_ready = 1'b0;
        miss_req  = 1'b0;
        #1;
        chk("wrap_fill_we", 32'(tlb_we), 32'b1000);
        tick();

        // Flush together with a miss: flush wins, miss follows, victim untouched
        flush    = 1'b1;
        miss_req = 1'b1;
        miss_vpn = 10'h021;
        #1;
        chk("fl_tlb_we", 32'(tlb_we), 32'b1111);
        chk("fl_wr_valid", 32'(tlb_wr_valid), 32'd0);
        chk("fl_wr_vpn", 32'(tlb_wr_vpn), 32'd0);
        chk("fl_wr_ppn", 32'(tlb_wr_ppn), 32'd0);
        chk("fl_mem_req", 32'(mem_req), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_after_we", 32'(tlb_we), 32'd0);
        tick();
        chk("fl_miss_mem_req", 32'(mem_req), 32'd1);
        chk("fl_miss_addr", 32'(mem_addr), 32'h0842);
        mem_ready = 1'b1;
        mem_rdata = 16'h8009;
        tick();
        mem_ready = 1'b0;
        miss_req  = 1'b0;
        #1;
        chk("fl_fill_we", 32'(tlb_we), 32'b0001);
        chk("fl_fill_ppn", 32'(tlb_wr_ppn), 32'h009);
        tick();

        // Reset during READ with mem_ready in the same cycle aborts the walk
        miss_req = 1'b1;
        miss_vpn = 10'h044;
        tick();
        chk("ab_mem_req", 32'(mem_req), 32'd1);
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'h8011;
        miss_req  = 1'b0;
        tick();
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("ab_mem_req_low", 32'(mem_req), 32'd0);
        chk("ab_no_we", 32'(tlb_we), 32'd0);
        chk("ab_no_done", 32'(done), 32'd0);
        chk("ab_fault_vpn", 32'(fault_vpn), 32'd0);
        tick();
        chk("ab_no_we2", 32'(tlb_we), 32'd0);
        chk("ab_no_done2", 32'(done), 32'd0);
        refill(10'h005, 16'h8077, 16'h080A, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
